// File: rtl/ss_update_ctrl.sv
// ----------------------------------------------------------------------------
// ss_update_ctrl
// Sequencer for the space-saving heavy-hitter engine. It takes a stream of
// item keys and drives a key CAM (key -> slot) and a counter CAM
// (slot -> count):
//   - hit:  read the slot count, write back count+1 (saturating)
//   - miss with a free slot: insert the key at slot fill_cnt with count 1
//   - miss with a full table: search ascending counts for a minimum slot,
//     then overwrite it with the new key and count min+1
// It also runs the counter CAM's 4-phase max reduction and clears both CAMs.
//
// Ports
//   clk, rstn                  clock, async active-low reset
//   clear_req, max_req         level requests, sampled in IDLE
//   item_valid/item_key/ready  key stream handshake
//   max_valid, max_value       max query result
//   busy, fill_cnt             status
//   evict_pulse                one pulse per eviction
//   kcam_*                     key CAM controls and results
//   ccam_*                     counter CAM controls and results
// ----------------------------------------------------------------------------
module ss_update_ctrl #(
   parameter int unsigned KEY_SIZE    = 16,
   parameter int unsigned WORD_SIZE   = 13,
   parameter int unsigned ENTRY_WIDTH = 7,
   parameter int unsigned ROW_NUM     = 128
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clear_req,
   input  logic                   item_valid,
   input  logic [KEY_SIZE-1:0]    item_key,
   output logic                   item_ready,
   input  logic                   max_req,
   output logic                   max_valid,
   output logic [WORD_SIZE-1:0]   max_value,
   output logic                   busy,
   output logic [ENTRY_WIDTH:0]   fill_cnt,
   output logic                   evict_pulse,
   output logic [KEY_SIZE-1:0]    kcam_data,
   output logic [ENTRY_WIDTH-1:0] kcam_addr,
   output logic                   kcam_write_en,
   output logic                   kcam_search_en,
   output logic                   kcam_reset,
   input  logic                   kcam_match,
   input  logic [ENTRY_WIDTH-1:0] kcam_addr_out,
   output logic [WORD_SIZE-1:0]   ccam_data,
   output logic [ENTRY_WIDTH-1:0] ccam_addr,
   output logic                   ccam_read_en,
   output logic                   ccam_write_en,
   output logic                   ccam_search_en,
   output logic                   ccam_reset,
   output logic                   ccam_max_en,
   input  logic [WORD_SIZE-1:0]   ccam_data_out,
   input  logic [ENTRY_WIDTH-1:0] ccam_addr_out,
   input  logic                   ccam_match,
   input  logic [WORD_SIZE-1:0]   ccam_max
);

   localparam int unsigned          FILL_W  = ENTRY_WIDTH + 1;
   localparam logic [FILL_W-1:0]    ROWS    = FILL_W'(ROW_NUM);
   localparam logic [WORD_SIZE-1:0] CNT_MAX = '1;
   localparam logic [WORD_SIZE-1:0] CNT_ONE = WORD_SIZE'(1);

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      LOOKUP,
      RD_CNT,
      WR_CNT,
      INSERT,
      FIND_MIN,
      EVICT,
      MAX0,
      MAX1,
      MAX2,
      MAX3,
      MAX_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [KEY_SIZE-1:0]    key_q, key_d;
   logic [ENTRY_WIDTH-1:0] slot_q, slot_d;
   logic [WORD_SIZE-1:0]   cnt_q, cnt_d;
   logic [WORD_SIZE-1:0]   min_val_q, min_val_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic [WORD_SIZE-1:0]   max_value_d;
   logic                   rdy_q;
   logic                   hit;

   // next-cycle values of the registered CAM controls
   logic [KEY_SIZE-1:0]    kcam_data_d;
   logic [ENTRY_WIDTH-1:0] kcam_addr_d;
   logic                   kcam_write_en_d, kcam_search_en_d, kcam_reset_d;
   logic [WORD_SIZE-1:0]   ccam_data_d;
   logic [ENTRY_WIDTH-1:0] ccam_addr_d;
   logic                   ccam_read_en_d, ccam_write_en_d, ccam_search_en_d;
   logic                   ccam_reset_d, ccam_max_en_d;
   logic                   max_valid_d, evict_pulse_d, busy_d, rdy_d;

   function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // rdy_q is a registered "in IDLE" flag so ready stays low during reset
   assign item_ready = rdy_q & ~clear_req & ~max_req;
   assign fill_cnt   = fill_q;

   // slots at or above fill_cnt hold stale data and must never count as a hit
   assign hit = kcam_match && (FILL_W'(kcam_addr_out) < fill_q);

   // state register, operands and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         key_q          <= '0;
         slot_q         <= '0;
         cnt_q          <= '0;
         min_val_q      <= CNT_ONE;
         fill_q         <= '0;
         max_value      <= '0;
         rdy_q          <= 1'b0;
         kcam_data      <= '0;
         kcam_addr      <= '0;
         kcam_write_en  <= 1'b0;
         kcam_search_en <= 1'b0;
         kcam_reset     <= 1'b0;
         ccam_data      <= '0;
         ccam_addr      <= '0;
         ccam_read_en   <= 1'b0;
         ccam_write_en  <= 1'b0;
         ccam_search_en <= 1'b0;
         ccam_reset     <= 1'b0;
         ccam_max_en    <= 1'b0;
         max_valid      <= 1'b0;
         evict_pulse    <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_q          <= key_d;
         slot_q         <= slot_d;
         cnt_q          <= cnt_d;
         min_val_q      <= min_val_d;
         fill_q         <= fill_d;
         max_value      <= max_value_d;
         rdy_q          <= rdy_d;
         kcam_data      <= kcam_data_d;
         kcam_addr      <= kcam_addr_d;
         kcam_write_en  <= kcam_write_en_d;
         kcam_search_en <= kcam_search_en_d;
         kcam_reset     <= kcam_reset_d;
         ccam_data      <= ccam_data_d;
         ccam_addr      <= ccam_addr_d;
         ccam_read_en   <= ccam_read_en_d;
         ccam_write_en  <= ccam_write_en_d;
         ccam_search_en <= ccam_search_en_d;
         ccam_reset     <= ccam_reset_d;
         ccam_max_en    <= ccam_max_en_d;
         max_valid      <= max_valid_d;
         evict_pulse    <= evict_pulse_d;
         busy           <= busy_d;
      end
   end

   // next state, next operands, and the controls for the state being entered
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      slot_d      = slot_q;
      cnt_d       = cnt_q;
      min_val_d   = min_val_q;
      fill_d      = fill_q;
      max_value_d = max_value;

      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
            end else if (max_req) begin
               state_d = MAX0;
            end else if (item_valid && item_ready) begin
               key_d   = item_key;
               state_d = LOOKUP;
            end
         end
         CLEAR: begin
            fill_d    = '0;
            min_val_d = CNT_ONE;
            state_d   = IDLE;
         end
         LOOKUP: begin
            if (hit) begin
               slot_d  = kcam_addr_out;
               state_d = RD_CNT;
            end else if (fill_q < ROWS) begin
               state_d = INSERT;
            end else begin
               state_d = FIND_MIN;
            end
         end
         RD_CNT: begin
            cnt_d   = ccam_data_out;
            state_d = WR_CNT;
         end
         WR_CNT:  state_d = IDLE;
         INSERT: begin
            fill_d  = fill_q + FILL_W'(1);
            state_d = IDLE;
         end
         // min_val only climbs; with a full table and saturating counts a
         // match is always reached
         FIND_MIN: begin
            if (ccam_match) begin
               slot_d  = ccam_addr_out;
               state_d = EVICT;
            end else begin
               min_val_d = min_val_q + CNT_ONE;
            end
         end
         EVICT:   state_d = IDLE;
         MAX0:    state_d = MAX1;
         MAX1:    state_d = MAX2;
         MAX2:    state_d = MAX3;
         MAX3:    state_d = MAX_DONE;
         // max_value lands on the edge that closes the max_valid cycle
         MAX_DONE: begin
            max_value_d = ccam_max;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      kcam_data_d      = key_d;
      kcam_addr_d      = '0;
      kcam_write_en_d  = 1'b0;
      kcam_search_en_d = 1'b0;
      kcam_reset_d     = 1'b0;
      ccam_data_d      = '0;
      ccam_addr_d      = '0;
      ccam_read_en_d   = 1'b0;
      ccam_write_en_d  = 1'b0;
      ccam_search_en_d = 1'b0;
      ccam_reset_d     = 1'b0;
      ccam_max_en_d    = 1'b0;
      max_valid_d      = 1'b0;
      evict_pulse_d    = 1'b0;
      busy_d           = (state_d != IDLE);
      rdy_d            = (state_d == IDLE);

      case (state_d)
         CLEAR: begin
            kcam_reset_d = 1'b1;
            ccam_reset_d = 1'b1;
         end
         LOOKUP: kcam_search_en_d = 1'b1;
         RD_CNT: begin
            ccam_read_en_d = 1'b1;
            ccam_addr_d    = slot_d;
         end
         WR_CNT: begin
            ccam_write_en_d = 1'b1;
            ccam_addr_d     = slot_d;
            ccam_data_d     = sat_inc(cnt_d);
         end
         INSERT: begin
            kcam_write_en_d = 1'b1;
            kcam_addr_d     = fill_d[ENTRY_WIDTH-1:0];
            ccam_write_en_d = 1'b1;
            ccam_addr_d     = fill_d[ENTRY_WIDTH-1:0];
            ccam_data_d     = CNT_ONE;
         end
         FIND_MIN: begin
            ccam_search_en_d = 1'b1;
            ccam_data_d      = min_val_d;
         end
         EVICT: begin
            kcam_write_en_d = 1'b1;
            kcam_addr_d     = slot_d;
            ccam_write_en_d = 1'b1;
            ccam_addr_d     = slot_d;
            ccam_data_d     = sat_inc(min_val_d);
            evict_pulse_d   = 1'b1;
         end
         // max_en must stay high for all four phases without a gap
         MAX0, MAX1, MAX2, MAX3: ccam_max_en_d = 1'b1;
         MAX_DONE: max_valid_d = 1'b1;
         default: ;
      endcase
   end

endmodule
